// File: rtl/mem_resp_pkg.sv
// +--------------------------------------------------------------------------+
// | mem_resp_pkg : shared state encoding and limits for mem_responder        |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
`default_nettype none

package mem_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int MAX_LATENCY = 15;
  localparam int CNT_W       = 4;

endpackage

`default_nettype wire

// File: rtl/mem_resp_array.sv
// +--------------------------------------------------------------------------+
// | mem_resp_array : single-port synchronous word RAM, one access per enable |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_resp_array
  import mem_resp_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q;

  // A write access returns zero so the completion cycle of a write shows no data.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_q       <= '0;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// +--------------------------------------------------------------------------+
// | mem_responder : fixed-latency stallable data memory for the MEM stage    |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 11,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Rd,
  input  logic              Wr,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              Err
);

  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("mem_responder: LATENCY must be within 1..15");
  end

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 done_q;
  logic                 stall_q;
  logic                 err_q;

  logic                  w_open;
  logic                  w_accept;
  logic                  w_illegal;
  logic                  w_busy_last;
  logic                  w_arr_en;
  logic                  w_arr_we;
  logic [DEPTH_LOG2-1:0] w_arr_addr;
  logic [DATA_W-1:0]     w_arr_wdata;
  logic [DATA_W-1:0]     w_arr_rdata;

  assign w_open      = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign w_accept    = w_open && (Rd ^ Wr) && !Addr[0];
  assign w_illegal   = w_open && ((Rd && Wr) || ((Rd || Wr) && Addr[0]));
  assign w_busy_last = (state_q == ST_BUSY) && (cnt_q <= CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      stall_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            if (LATENCY == 1) begin
              state_q <= ST_DONE;
              cnt_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_BUSY;
              cnt_q   <= LOAD_CNT;
              stall_q <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= w_illegal;
          end
        end
        ST_BUSY: begin
          if (w_busy_last) begin
            state_q <= ST_DONE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q - CNT_W'(1);
            stall_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // With a one-cycle latency the array is accessed at the accepting edge,
  // straight from the request inputs; otherwise from the latched request.
  if (LATENCY == 1) begin : g_lat1
    assign w_arr_en    = w_accept && rst_n;
    assign w_arr_we    = Wr;
    assign w_arr_addr  = Addr[DEPTH_LOG2:1];
    assign w_arr_wdata = DataIn;
  end else begin : g_latn
    logic                  wr_q;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [DATA_W-1:0]     data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_q   <= 1'b0;
        addr_q <= '0;
        data_q <= '0;
      end else if (w_accept) begin
        wr_q   <= Wr;
        addr_q <= Addr[DEPTH_LOG2:1];
        data_q <= DataIn;
      end
    end

    assign w_arr_en    = w_busy_last;
    assign w_arr_we    = wr_q;
    assign w_arr_addr  = addr_q;
    assign w_arr_wdata = data_q;
  end

  if (ADDR_W > DEPTH_LOG2 + 1) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^Addr[ADDR_W-1:DEPTH_LOG2+1];
  end

  mem_resp_array #(
    .DATA_W    (DATA_W),
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk    (clk),
    .en_i   (w_arr_en),
    .we_i   (w_arr_we),
    .addr_i (w_arr_addr),
    .wdata_i(w_arr_wdata),
    .rdata_o(w_arr_rdata)
  );

  assign DataOut = done_q ? w_arr_rdata : '0;
  assign Done    = done_q;
  assign Stall   = stall_q;
  assign Err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// +--------------------------------------------------------------------------+
// | tb_mem_responder : scoreboard bench for LATENCY=4 and LATENCY=1 builds   |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        rd, wr;
  logic [15:0] addr, din;
  logic [15:0] dout;
  logic        done, stall, err;

  logic        rd1, wr1;
  logic [15:0] addr1, din1;
  logic [15:0] dout1;
  logic        done1, stall1, err1;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] exp0, exp1;

  always #5 clk = ~clk;

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(11), .LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n), .Rd(rd), .Wr(wr), .Addr(addr), .DataIn(din),
    .DataOut(dout), .Done(done), .Stall(stall), .Err(err)
  );

  mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(11), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .Rd(rd1), .Wr(wr1), .Addr(addr1), .DataIn(din1),
    .DataOut(dout1), .Done(done1), .Stall(stall1), .Err(err1)
  );

  // Scoreboard monitors: every Done pops one expected word, DataOut must be 0 otherwise.
  always @(posedge clk) begin
    #1;
    n_cmp++;
    if (done === 1'b1) begin
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got Done=1 DataOut=%h, want Done=0", dout);
      end else begin
        exp0 = q0.pop_front();
        if (dout !== exp0) begin
          n_fail++;
          $display("FAIL done_data: got DataOut=%h, want %h", dout, exp0);
        end
      end
    end else if (dout !== 16'h0) begin
      n_fail++;
      $display("FAIL dataout_idle: got DataOut=%h with Done=%b, want 0000", dout, done);
    end
  end

  always @(posedge clk) begin
    #1;
    n_cmp++;
    if (done1 === 1'b1) begin
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL lat1_unexpected_done: got Done=1 DataOut=%h, want Done=0", dout1);
      end else begin
        exp1 = q1.pop_front();
        if (dout1 !== exp1) begin
          n_fail++;
          $display("FAIL lat1_done_data: got DataOut=%h, want %h", dout1, exp1);
        end
      end
    end else if (dout1 !== 16'h0) begin
      n_fail++;
      $display("FAIL lat1_dataout_idle: got DataOut=%h, want 0000", dout1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit is_wr, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] e);
    int t;
    rd = !is_wr; wr = is_wr; addr = a; din = d;
    q0.push_back(e);
    step();
    rd = 1'b0; wr = 1'b0;
    t = 0;
    while (done !== 1'b1 && t < 20) begin
      step();
      t++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL req_timeout: got no Done for addr %h, want Done within 20 cycles", a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rd = 0; wr = 0; addr = 0; din = 0;
    rd1 = 0; wr1 = 0; addr1 = 0; din1 = 0;
    repeat (3) step();
    n_cmp++;
    if ({done, stall, err} !== 3'b000 || dout !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got D/S/E=%b%b%b DataOut=%h, want 000 0000",
               done, stall, err, dout);
    end
    n_cmp++;
    if ({done1, stall1, err1} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_outputs_lat1: got D/S/E=%b%b%b, want 000", done1, stall1, err1);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    wr = 1; addr = 16'h0010; din = 16'hBEEF;
    q0.push_back(16'h0);
    step();
    wr = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (stall !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL wr_busy[%0d]: got Stall=%b Done=%b, want 1 0", i, stall, done);
      end
      step();
    end
    n_cmp++;
    if (done !== 1'b1 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_done: got Done=%b Stall=%b, want 1 0", done, stall);
    end
    rd = 1; addr = 16'h0010;
    q0.push_back(16'hBEEF);
    step();
    rd = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (stall !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_busy[%0d]: got Stall=%b Done=%b, want 1 0", i, stall, done);
      end
      step();
    end
    n_cmp++;
    if (done !== 1'b1 || dout !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL rd_done: got Done=%b DataOut=%h, want 1 BEEF", done, dout);
    end
    step();
    n_cmp++;
    if (done !== 1'b0 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_idle: got Done=%b Stall=%b, want 0 0", done, stall);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] a_tab [2];
    logic        w_tab [2];
    a_tab[0] = 16'h0020; w_tab[0] = 1'b1;
    a_tab[1] = 16'h0021; w_tab[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rd = 1; wr = w_tab[i]; addr = a_tab[i];
      step();
      rd = 0; wr = 0;
      n_cmp++;
      if (err !== 1'b1 || done !== 1'b0 || stall !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_err[%0d]: got Err=%b Done=%b Stall=%b, want 1 0 0",
                 i, err, done, stall);
      end
      step();
      n_cmp++;
      if (err !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_after[%0d]: got Err=%b Done=%b, want 0 0", i, err, done);
      end
    end
  endtask

  task automatic test_busy_inputs();
    int nd;
    do_req(1'b1, 16'h0040, 16'h4444, 16'h0);
    step();
    wr = 1; addr = 16'h0030; din = 16'h3333;
    q0.push_back(16'h0);
    step();
    wr = 0; rd = 1; addr = 16'h0040;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) rd = 0;
      if (done === 1'b1) nd++;
      step();
    end
    n_cmp++;
    if (nd != 1) begin
      n_fail++;
      $display("FAIL busy_ignore: got %0d Done pulses, want 1", nd);
    end
    do_req(1'b0, 16'h0040, 16'h0, 16'h4444);
    step();
  endtask

  task automatic test_reset_midop();
    do_req(1'b1, 16'h0050, 16'h5555, 16'h0);
    step();
    wr = 1; addr = 16'h0050; din = 16'h1234;
    step();
    wr = 0;
    step();
    n_cmp++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL midop_busy: got Stall=%b, want 1", stall);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({done, stall, err} !== 3'b000 || dout !== 16'h0) begin
      n_fail++;
      $display("FAIL midop_reset: got D/S/E=%b%b%b DataOut=%h, want 000 0000",
               done, stall, err, dout);
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (6) step();
    do_req(1'b0, 16'h0050, 16'h0, 16'h5555);
    step();
  endtask

  task automatic test_alias();
    do_req(1'b1, 16'h1002, 16'hA5A5, 16'h0);
    do_req(1'b0, 16'h0002, 16'h0, 16'hA5A5);
    step();
  endtask

  task automatic test_lat1();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 16'($urandom_range(0, 65535));
      wr1 = 1; rd1 = 0; addr1 = 16'h0002; din1 = v;
      q1.push_back(16'h0);
      step();
      n_cmp++;
      if (done1 !== 1'b1 || stall1 !== 1'b0) begin
        n_fail++;
        $display("FAIL lat1_wr[%0d]: got Done=%b Stall=%b, want 1 0", i, done1, stall1);
      end
      wr1 = 0; rd1 = 1;
      q1.push_back(v);
      step();
      n_cmp++;
      if (done1 !== 1'b1 || stall1 !== 1'b0 || dout1 !== v) begin
        n_fail++;
        $display("FAIL lat1_rd[%0d]: got Done=%b Stall=%b DataOut=%h, want 1 0 %h",
                 i, done1, stall1, dout1, v);
      end
    end
    rd1 = 0;
    step();
    n_cmp++;
    if (done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL lat1_idle: got Done=%b, want 0", done1);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_illegal();
    test_busy_inputs();
    test_reset_midop();
    test_alias();
    test_lat1();
    repeat (2) step();
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
